// File: rtl/fixed_point_pkg.sv
// Shared Q7.8 sign-magnitude definitions for the multiply arbiter slice.
//   fixed_t   : 16-bit word, bit 15 sign, bits 14:8 integer, bits 7:0 fraction
//   FRAC_BITS : number of fraction bits
//   INT_BITS  : number of integer bits
//   MAG_W     : magnitude width (everything below the sign bit)
//   occ_t     : pipeline occupancy, encoded as {s1_valid, s2_valid}
package fixed_point_pkg;

  typedef logic [15:0] fixed_t;

  localparam int FRAC_BITS = 8;
  localparam int INT_BITS  = 7;
  localparam int MAG_W     = INT_BITS + FRAC_BITS;

  // The encoding is deliberately {s1_valid, s2_valid} so the two valid
  // flags can be read straight out of the state bits.
  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'b00,
    OCC_S2ONLY = 2'b01,
    OCC_S1ONLY = 2'b10,
    OCC_FULL   = 2'b11
  } occ_t;

endpackage

// File: rtl/fixed_mult_core.sv
// Combinational Q7.8 sign-magnitude multiply.
//   a, b     : operands (fixed_t)
//   product  : {sign xor, mag[22:8]}, fraction truncated
//   overflow : set when any magnitude bit above the Q7.8 range was dropped
module fixed_mult_core
  import fixed_point_pkg::*;
(
  input  fixed_t a,
  input  fixed_t b,
  output fixed_t product,
  output logic   overflow
);

  logic [2*MAG_W-1:0]   w_mag;
  logic [FRAC_BITS-1:0] w_unusedFrac;

  assign w_mag = {{MAG_W{1'b0}}, a[MAG_W-1:0]} * {{MAG_W{1'b0}}, b[MAG_W-1:0]};

  // Low fraction bits are truncated, not rounded.
  assign w_unusedFrac = w_mag[FRAC_BITS-1:0];

  // The sign is always the XOR of the operand signs, so negative zero survives.
  assign product  = {a[MAG_W] ^ b[MAG_W], w_mag[MAG_W+FRAC_BITS-1:FRAC_BITS]};
  assign overflow = |w_mag[2*MAG_W-1:MAG_W+FRAC_BITS];

endmodule

// File: rtl/fixed_mult_arbiter.sv
// Round-robin arbiter in front of a two-stage pipelined Q7.8 multiplier.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   req_valid    : per-requester operand-pair valid
//   req_ready    : per-requester accept (one-hot or zero, combinational)
//   req_a, req_b : packed operands, requester i in bits [16i+15:16i]
//   rsp_valid    : registered result valid
//   rsp_ready    : downstream accepts the result
//   rsp_id       : requester that issued the result
//   rsp_product  : Q7.8 sign-magnitude product
//   rsp_overflow : magnitude bits were lost by truncation
module fixed_mult_arbiter
  import fixed_point_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output fixed_t                rsp_product,
  output logic                  rsp_overflow
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  occ_t            r_state;
  occ_t            w_stateNext;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptrNext;

  fixed_t          r_s1A;
  fixed_t          r_s1B;
  logic [ID_W-1:0] r_s1Id;
  fixed_t          r_s2Product;
  logic            r_s2Overflow;
  logic [ID_W-1:0] r_s2Id;

  logic               w_s1Valid;
  logic               w_s2Valid;
  logic               w_s2Load;
  logic               w_s1Free;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_rot;
  logic               w_grantFound;
  logic [ID_W-1:0]    w_offset;
  logic [ID_W:0]      w_grantSum;
  logic [ID_W-1:0]    w_grantIdx;
  fixed_t             w_coreProduct;
  logic               w_coreOverflow;

  assign w_s1Valid = (r_state == OCC_S1ONLY) || (r_state == OCC_FULL);
  assign w_s2Valid = (r_state == OCC_S2ONLY) || (r_state == OCC_FULL);

  // S1 advances whenever S2 is empty or is being drained this cycle, which is
  // what lets a new request enter without a bubble.
  assign w_s2Load = w_s1Valid && (!w_s2Valid || rsp_ready);
  assign w_s1Free = !w_s1Valid || w_s2Load;

  // Rotate the request vector so bit 0 is the requester at the pointer; the
  // lowest set bit is then the round-robin winner's distance from the pointer.
  assign w_rot        = NUM_REQ'({req_valid, req_valid} >> r_ptr);
  assign w_grantFound = |w_rot;

  always_comb begin
    w_offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_offset = ID_W'(k);
      end
    end
  end

  // Map the distance back to an absolute index with wrap-around.
  always_comb begin
    w_grantSum = {1'b0, r_ptr} + {1'b0, w_offset};
    if (w_grantSum >= NUM_REQ_W) begin
      w_grantIdx = ID_W'(w_grantSum - NUM_REQ_W);
    end else begin
      w_grantIdx = ID_W'(w_grantSum);
    end
  end

  assign w_ptrNext = (w_grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
  assign w_accept  = !rst && w_grantFound && w_s1Free;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grantIdx] = 1'b1;
    end
  end

  // Occupancy next-state: S1 fills on accept and empties when it moves to S2;
  // S2 fills on load and empties when its result transfers.
  always_comb begin
    w_stateNext = r_state;
    w_stateNext = occ_t'({w_accept || (w_s1Valid && !w_s2Load),
                          w_s2Load || (w_s2Valid && !rsp_ready)});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath registers; reset clears them so the response port reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_s1A        <= '0;
      r_s1B        <= '0;
      r_s1Id       <= '0;
      r_s2Product  <= '0;
      r_s2Overflow <= 1'b0;
      r_s2Id       <= '0;
    end else begin
      if (w_accept) begin
        r_ptr  <= w_ptrNext;
        r_s1A  <= req_a[{w_grantIdx, 4'b0000} +: 16];
        r_s1B  <= req_b[{w_grantIdx, 4'b0000} +: 16];
        r_s1Id <= w_grantIdx;
      end
      if (w_s2Load) begin
        r_s2Product  <= w_coreProduct;
        r_s2Overflow <= w_coreOverflow;
        r_s2Id       <= r_s1Id;
      end
    end
  end

  fixed_mult_core u_core (
    .a        (r_s1A),
    .b        (r_s1B),
    .product  (w_coreProduct),
    .overflow (w_coreOverflow)
  );

  assign rsp_valid    = w_s2Valid;
  assign rsp_id       = r_s2Id;
  assign rsp_product  = r_s2Product;
  assign rsp_overflow = r_s2Overflow;

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Self-checking bench for fixed_mult_arbiter: directed cases plus randomized
// traffic compared against a queue-based model of a two-deep pipeline.
module tb_fixed_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_product;
  logic                  rsp_overflow;

  always #5 clk = ~clk;

  fixed_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product),
    .rsp_overflow (rsp_overflow)
  );

  // Model: in-flight results in issue order; age counts edges since accept.
  // The head is visible on the response port once it has aged one edge.
  typedef struct {
    int id;
    int prod;
    int ovf;
    int age;
  } exp_t;

  exp_t mQ[$];
  int   mPtr        = 0;
  bit   mAfterReset = 1'b0;
  int   checks      = 0;
  int   errors      = 0;

  logic [NUM_REQ-1:0] sReqReady;
  logic               sRspValid;
  logic [ID_W-1:0]    sRspId;
  logic [15:0]        sRspProduct;
  logic               sRspOverflow;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void refMult(input logic [15:0] a, input logic [15:0] b,
                                  output int prod, output int ovf);
    int mag;
    mag  = int'(a & 16'h7fff) * int'(b & 16'h7fff);
    prod = (int'(a[15] ^ b[15]) << 15) | ((mag >> 8) & 32'h7fff);
    ovf  = ((mag >> 23) != 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] randOperand();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'($urandom);
      1:       v = {1'($urandom), 5'd0, 10'($urandom)};
      2:       v = {1'($urandom), 2'b11, 13'($urandom)};
      default: v = {1'($urandom), 15'd0};
    endcase
    return v;
  endfunction

  task automatic refreshRequests(input int pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] && ($urandom_range(0, 99) < pct)) begin
        req_valid[i]        = 1'b1;
        req_a[16*i +: 16]   = randOperand();
        req_b[16*i +: 16]   = randOperand();
      end
    end
  endtask

  // One clock cycle: inputs were set after the previous edge; sample and
  // compare at the falling edge, advance the model, then step past the edge.
  task automatic applyStimulus(input string tag);
    bit                 found;
    int                 g;
    int                 grantTaken;
    bit                 expRspValid;
    bit                 canAccept;
    logic [NUM_REQ-1:0] expReady;
    exp_t               e;
    @(negedge clk);
    sReqReady    = req_ready;
    sRspValid    = rsp_valid;
    sRspId       = rsp_id;
    sRspProduct  = rsp_product;
    sRspOverflow = rsp_overflow;

    expRspValid = (mQ.size() > 0) && (mQ[0].age >= 1);
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (mPtr + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    canAccept = (mQ.size() < 2) || rsp_ready;
    expReady  = '0;
    if (!rst && found && canAccept) expReady[g] = 1'b1;

    if (mAfterReset) begin
      checkOutput({tag, "/zero_valid"}, sRspValid, 0);
      checkOutput({tag, "/zero_id"}, sRspId, 0);
      checkOutput({tag, "/zero_product"}, sRspProduct, 0);
      checkOutput({tag, "/zero_overflow"}, sRspOverflow, 0);
    end
    checkOutput({tag, "/req_ready"}, sReqReady, expReady);
    checkOutput({tag, "/rsp_valid"}, sRspValid, expRspValid);
    if (expRspValid) begin
      checkOutput({tag, "/rsp_id"}, sRspId, mQ[0].id);
      checkOutput({tag, "/rsp_product"}, sRspProduct, mQ[0].prod);
      checkOutput({tag, "/rsp_overflow"}, sRspOverflow, mQ[0].ovf);
    end

    grantTaken = -1;
    if (rst) begin
      mQ.delete();
      mPtr        = 0;
      mAfterReset = 1'b1;
    end else begin
      mAfterReset = 1'b0;
      if (expRspValid && rsp_ready) void'(mQ.pop_front());
      foreach (mQ[i]) mQ[i].age++;
      if (expReady != '0) begin
        e.id  = g;
        e.age = 0;
        refMult(req_a[16*g +: 16], req_b[16*g +: 16], e.prod, e.ovf);
        mQ.push_back(e);
        mPtr       = (g + 1) % NUM_REQ;
        grantTaken = g;
      end
    end
    @(posedge clk);
    #1;
    if (grantTaken >= 0) req_valid[grantTaken] = 1'b0;
  endtask

  task automatic resetDut();
    req_valid = '0;
    rst = 1'b1;
    applyStimulus("reset");
    rst = 1'b0;
    applyStimulus("post_reset");
  endtask

  task automatic directedMult(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] expProd, input logic expOvf);
    resetDut();
    rsp_ready     = 1'b1;
    req_a[15:0]   = a;
    req_b[15:0]   = b;
    req_valid     = 4'b0001;
    applyStimulus(tag);
    checkOutput({tag, "/accept"}, sReqReady, 4'b0001);
    applyStimulus(tag);
    checkOutput({tag, "/not_yet"}, sRspValid, 0);
    applyStimulus(tag);
    checkOutput({tag, "/valid"}, sRspValid, 1);
    checkOutput({tag, "/id"}, sRspId, 0);
    checkOutput({tag, "/product"}, sRspProduct, expProd);
    checkOutput({tag, "/overflow"}, sRspOverflow, expOvf);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;

    directedMult("basic", 16'h0180, 16'h0200, 16'h0300, 1'b0);
    directedMult("neg", 16'h8180, 16'h0200, 16'h8300, 1'b0);
    directedMult("negzero", 16'h8000, 16'h0100, 16'h8000, 1'b0);
    directedMult("ovf", 16'h4000, 16'h0400, 16'h0000, 1'b1);

    // All requesters busy with a free-flowing output: strict rotation.
    resetDut();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      refreshRequests(100);
      applyStimulus("rr");
      checkOutput("rr/grant", sReqReady, 1 << (k % NUM_REQ));
      if (k >= 2) checkOutput("rr/rsp_id", sRspId, (k - 2) % NUM_REQ);
    end

    // Output stalled for three cycles: two accepts, then everything blocked.
    resetDut();
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) rsp_ready = 1'b1;
      refreshRequests(100);
      applyStimulus("bp");
      case (k)
        0: checkOutput("bp/grant0", sReqReady, 4'b0001);
        1: checkOutput("bp/grant1", sReqReady, 4'b0010);
        2: begin
          checkOutput("bp/blocked", sReqReady, 4'b0000);
          checkOutput("bp/held_id", sRspId, 0);
        end
        3: begin
          checkOutput("bp/grant2", sReqReady, 4'b0100);
          checkOutput("bp/drain_id0", sRspId, 0);
        end
        4: checkOutput("bp/drain_id1", sRspId, 1);
        5: checkOutput("bp/drain_id2", sRspId, 2);
        default: checkOutput("bp/drain_id3", sRspId, 3);
      endcase
    end

    // Reset with two operations in flight.
    resetDut();
    rsp_ready = 1'b0;
    refreshRequests(100);
    applyStimulus("midrst_fill");
    refreshRequests(100);
    applyStimulus("midrst_fill");
    refreshRequests(100);
    rst = 1'b1;
    applyStimulus("midrst");
    checkOutput("midrst/ready_in_reset", sReqReady, 0);
    rst = 1'b0;
    req_valid = '0;
    applyStimulus("midrst_post");
    checkOutput("midrst/valid_after", sRspValid, 0);
    rsp_ready = 1'b1;
    refreshRequests(100);
    applyStimulus("midrst_first");
    checkOutput("midrst/first_grant", sReqReady, 4'b0001);
    for (int k = 0; k < 4; k++) applyStimulus("midrst_tail");

    // Randomized traffic with random backpressure and occasional resets.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      refreshRequests(40);
      if ($urandom_range(0, 199) == 0) resetDut();
      else applyStimulus("rand");
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) applyStimulus("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
